// File: rtl/nlo_spike_detector.sv
// nlo_spike_detector: runtime-selectable non-linear operator (TKEO/ED/ASO/ADO) + threshold + refractory FSM.
// Latency: 2 cycles from an accepted sample to out_valid_o / op_out_o / event_o.
// Backpressure: none; one sample per cycle may be offered on in_valid_i and is always taken.
//
// Optional feature macro: NLO_PEAK_HOLD_EN. When defined, peak_out_o reports the largest
// op_out_o seen from an event through the end of its refractory window; otherwise it is 0.
//
// Ports:
//   clk_i, rst_ni      clock (rising edge) and asynchronous active-low reset
//   in_valid_i         sample strobe, data_in_i sampled when high
//   data_in_i          signed sample
//   cfg_load_i         one-cycle pulse latching mode_i, k_sel_i, threshold_i, refract_len_i;
//                      clears history, warmup and in-flight results (a sample in the same cycle is dropped)
//   mode_i             0=TKEO, 1=ED, 2=ASO, 3=ADO
//   k_sel_i            delay k, clamped into 1..K_MAX
//   threshold_i        signed threshold, event when op_out_o > threshold (strict)
//   refract_len_i      number of results suppressed after an event
//   out_valid_o        one-cycle result strobe
//   op_out_o           signed scaled operator value (holds between strobes)
//   event_o            spike pulse, coincident with out_valid_o
//   peak_out_o         peak of the last event window (0 when peak hold is not built)
//   busy_o             high while warming up or refractory
module nlo_spike_detector #(
    parameter int DATA_W    = 16,
    parameter int K_MAX     = 8,
    parameter int OUT_W     = 2 * DATA_W + 2,
    parameter int SCALE_SH  = 0,
    parameter int REFRACT_W = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          in_valid_i,
    input  logic signed [DATA_W-1:0]      data_in_i,
    input  logic                          cfg_load_i,
    input  logic [1:0]                    mode_i,
    input  logic [$clog2(K_MAX+1)-1:0]    k_sel_i,
    input  logic signed [OUT_W-1:0]       threshold_i,
    input  logic [REFRACT_W-1:0]          refract_len_i,
    output logic                          out_valid_o,
    output logic signed [OUT_W-1:0]       op_out_o,
    output logic                          event_o,
    output logic signed [OUT_W-1:0]       peak_out_o,
    output logic                          busy_o
);

    localparam int KW       = $clog2(K_MAX + 1);
    localparam int DW       = DATA_W + 1;
    // TKEO always needs two previous samples, so the history is at least two deep.
    localparam int NEED_MAX = (K_MAX > 2) ? K_MAX : 2;
    localparam int HIST_N   = NEED_MAX;
    localparam int CW       = $clog2(NEED_MAX + 1);

    localparam logic [1:0] MODE_TKEO = 2'd0;
    localparam logic [1:0] MODE_ED   = 2'd1;
    localparam logic [1:0] MODE_ASO  = 2'd2;
    localparam logic [1:0] MODE_ADO  = 2'd3;

    typedef enum logic [1:0] {
        ST_WARMUP  = 2'd0,
        ST_RUN     = 2'd1,
        ST_REFRACT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    logic [1:0]              mode_q;
    logic [KW-1:0]           k_q;
    logic signed [OUT_W-1:0] thr_q;
    logic [REFRACT_W-1:0]    rlen_q;
    logic [KW-1:0]           k_clamp_d;

    always_comb begin
        k_clamp_d = k_sel_i;
        if (k_sel_i == '0) begin
            k_clamp_d = KW'(1);
        end else if (k_sel_i > KW'(K_MAX)) begin
            k_clamp_d = KW'(K_MAX);
        end
    end

    // ------------------------------------------------------------------
    // History and stage 1 (differences and products)
    // ------------------------------------------------------------------
    // hist_q[0] is x[n-1] relative to the sample currently on data_in_i.
    logic signed [DATA_W-1:0] hist_q [HIST_N];
    logic [CW-1:0]            cnt_q;      // accepted samples held in history, saturating
    logic                     s1_vld_q;
    logic signed [OUT_W-1:0]  s1_a_q;
    logic signed [OUT_W-1:0]  s1_b_q;

    logic signed [DATA_W-1:0] x_k;
    logic signed [DW-1:0]     xd_n, xd_1, xd_2, xd_k, diff_d;
    logic signed [OUT_W-1:0]  xo_n, xo_1, xo_2, do_d;
    logic signed [OUT_W-1:0]  a_d, b_d;
    logic [CW-1:0]            need_d;
    logic                     warm_ok_d;

    function automatic logic signed [DW-1:0] ext_dw(input logic signed [DATA_W-1:0] v);
        return {v[DATA_W-1], v};
    endfunction

    function automatic logic signed [OUT_W-1:0] ext_ow(input logic signed [DW-1:0] v);
        return {{(OUT_W - DW){v[DW-1]}}, v};
    endfunction

    // x[n-k] selected from the history by the latched k.
    always_comb begin
        x_k = '0;
        for (int i = 0; i < K_MAX; i++) begin
            if (k_q == KW'(i + 1)) begin
                x_k = hist_q[i];
            end
        end
    end

    always_comb begin
        xd_n   = ext_dw(data_in_i);
        xd_1   = ext_dw(hist_q[0]);
        xd_2   = ext_dw(hist_q[1]);
        xd_k   = ext_dw(x_k);
        diff_d = xd_n - xd_k;
        xo_n   = ext_ow(xd_n);
        xo_1   = ext_ow(xd_1);
        xo_2   = ext_ow(xd_2);
        do_d   = ext_ow(diff_d);

        // Every operator is reduced to a - b so stage 2 is a single subtract.
        a_d = '0;
        b_d = '0;
        case (mode_q)
            MODE_TKEO: begin
                a_d = xo_1 * xo_1;
                b_d = xo_n * xo_2;
            end
            MODE_ED:   a_d = do_d * do_d;
            MODE_ASO:  a_d = xo_n * do_d;
            MODE_ADO:  a_d = do_d[OUT_W-1] ? -do_d : do_d;
            default:   a_d = '0;
        endcase

        need_d    = (mode_q == MODE_TKEO) ? CW'(2) : CW'(k_q);
        warm_ok_d = (cnt_q >= need_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q   <= MODE_TKEO;
            k_q      <= KW'(1);
            thr_q    <= {1'b0, {(OUT_W - 1){1'b1}}};
            rlen_q   <= '0;
            cnt_q    <= '0;
            s1_vld_q <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            for (int i = 0; i < HIST_N; i++) begin
                hist_q[i] <= '0;
            end
        end else if (cfg_load_i) begin
            // New configuration starts from an empty history; anything in
            // stage 1 belongs to the old configuration and is dropped.
            mode_q   <= mode_i;
            k_q      <= k_clamp_d;
            thr_q    <= threshold_i;
            rlen_q   <= refract_len_i;
            cnt_q    <= '0;
            s1_vld_q <= 1'b0;
            for (int i = 0; i < HIST_N; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            s1_vld_q <= in_valid_i && warm_ok_d;
            if (in_valid_i) begin
                s1_a_q    <= a_d;
                s1_b_q    <= b_d;
                hist_q[0] <= data_in_i;
                for (int i = 1; i < HIST_N; i++) begin
                    hist_q[i] <= hist_q[i-1];
                end
                if (cnt_q < CW'(NEED_MAX)) begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: combine, scale, compare, FSM
    // ------------------------------------------------------------------
    state_t                  state_q;
    logic [REFRACT_W-1:0]    rcnt_q;
    logic                    out_valid_q;
    logic signed [OUT_W-1:0] op_q;
    logic                    event_q;
    logic                    busy_q;

    logic signed [OUT_W-1:0] res_d;
    logic signed [OUT_W-1:0] res_sh_d;
    logic                    fire_d;

    always_comb begin
        res_d    = s1_a_q - s1_b_q;
        res_sh_d = res_d >>> SCALE_SH;
        // The first result out of WARMUP is judged as if already in RUN.
        fire_d   = (state_q != ST_REFRACT) && (res_sh_d > thr_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_WARMUP;
            rcnt_q      <= '0;
            out_valid_q <= 1'b0;
            op_q        <= '0;
            event_q     <= 1'b0;
            busy_q      <= 1'b1;
        end else if (cfg_load_i) begin
            state_q     <= ST_WARMUP;
            rcnt_q      <= '0;
            out_valid_q <= 1'b0;
            event_q     <= 1'b0;
            busy_q      <= 1'b1;
        end else if (s1_vld_q) begin
            out_valid_q <= 1'b1;
            op_q        <= res_sh_d;
            event_q     <= fire_d;
            if (fire_d) begin
                if (rlen_q != '0) begin
                    state_q <= ST_REFRACT;
                    rcnt_q  <= rlen_q;
                    busy_q  <= 1'b1;
                end else begin
                    state_q <= ST_RUN;
                    busy_q  <= 1'b0;
                end
            end else if (state_q == ST_REFRACT) begin
                // Leave on the result that takes the count to zero, so the
                // following result is allowed to fire again.
                rcnt_q <= rcnt_q - REFRACT_W'(1);
                if (rcnt_q == REFRACT_W'(1)) begin
                    state_q <= ST_RUN;
                    busy_q  <= 1'b0;
                end
            end else begin
                state_q <= ST_RUN;
                busy_q  <= 1'b0;
            end
        end else begin
            out_valid_q <= 1'b0;
            event_q     <= 1'b0;
        end
    end

    assign out_valid_o = out_valid_q;
    assign op_out_o    = op_q;
    assign event_o     = event_q;
    assign busy_o      = busy_q;

`ifdef NLO_PEAK_HOLD_EN
    // Peak of the event window: captured on the event, raised by any larger
    // result while refractory (including the one that ends it), then frozen.
    logic signed [OUT_W-1:0] peak_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            peak_q <= '0;
        end else if (cfg_load_i) begin
            peak_q <= '0;
        end else if (s1_vld_q) begin
            if (fire_d) begin
                peak_q <= res_sh_d;
            end else if ((state_q == ST_REFRACT) && (res_sh_d > peak_q)) begin
                peak_q <= res_sh_d;
            end
        end
    end

    assign peak_out_o = peak_q;
`else
    assign peak_out_o = '0;
`endif

endmodule

// File: tb/tb_nlo_spike_detector.sv
module tb_nlo_spike_detector;

    localparam int DATA_W    = 16;
    localparam int K_MAX     = 8;
    localparam int OUT_W     = 2 * DATA_W + 2;
    localparam int SCALE_SH  = 0;
    localparam int REFRACT_W = 8;
    localparam longint TMAX  = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     in_valid;
    logic signed [DATA_W-1:0] data_in;
    logic                     cfg_load;
    logic [1:0]               mode;
    logic [3:0]               k_sel;
    logic signed [OUT_W-1:0]  threshold;
    logic [REFRACT_W-1:0]     refract_len;
    logic                     out_valid;
    logic signed [OUT_W-1:0]  op_out;
    logic                     spike;
    logic signed [OUT_W-1:0]  peak_out;
    logic                     busy;

    always #5 clk = ~clk;

    nlo_spike_detector #(
        .DATA_W(DATA_W), .K_MAX(K_MAX), .OUT_W(OUT_W),
        .SCALE_SH(SCALE_SH), .REFRACT_W(REFRACT_W)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .data_in_i(data_in),
        .cfg_load_i(cfg_load), .mode_i(mode), .k_sel_i(k_sel), .threshold_i(threshold),
        .refract_len_i(refract_len), .out_valid_o(out_valid), .op_out_o(op_out),
        .event_o(spike), .peak_out_o(peak_out), .busy_o(busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Result monitor: every out_valid strobe is recorded away from the active edge.
    longint q_op[$];
    bit     q_ev[$];
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            q_op.push_back(longint'(op_out));
            q_ev.push_back(spike);
        end
    end

    task automatic clear_q();
        q_op.delete();
        q_ev.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            cfg_load = 1'b0;
        end
    endtask

    task automatic send(input int x);
        @(posedge clk); #1;
        in_valid = 1'b1;
        cfg_load = 1'b0;
        data_in  = DATA_W'(x);
    endtask

    task automatic configure(input logic [1:0] m, input logic [3:0] k, input longint t, input logic [7:0] r);
        @(posedge clk); #1;
        in_valid    = 1'b0;
        cfg_load    = 1'b1;
        mode        = m;
        k_sel       = k;
        threshold   = OUT_W'(t);
        refract_len = r;
        @(posedge clk); #1;
        cfg_load = 1'b0;
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [3:0] k;
        longint     thr;
        logic [7:0] rlen;
        int         ns;
        int         ne;
        bit         busy_end;
    } vec_t;

    localparam int NV = 9;
    vec_t tbl [NV];

    int samp [50] = '{
        0, 0, 0, 1000, 0, 0,                 // V0 TKEO
        0, 0, 200, 200, 0, 0, 0,             // V1 ED k1 refract 2
        0, 10, 20, 30, 40, 50, 60, 70,       // V2 ADO k3 ramp
        50, -50,                             // V3 ASO k1
        10, -10, 20,                         // V4 ASO k0 (clamped to 1), thr 0, refract 0
        0, 0, 0, 0, 0, 0, 0, 0, 100, 100,    // V5 ED k15 (clamped to 8), thr equal to result
        3, -4, 5, 2, 0,                      // V6 TKEO thr 0 refract 1
        10, 0, 5, 0,                         // V7 ASO k2 negative threshold
        0, 3, 10, -2, 6                      // V8 ED k2
    };
    longint exp_op [28] = '{
        0, 0, 1000000, 0,
        0, 40000, 0, 40000, 0, 0,
        30, 30, 30, 30, 30,
        5000,
        200, 600,
        10000, 10000,
        1, 33, 4,
        -25, 0,
        100, 25, 16
    };
    bit exp_ev [28] = '{
        0, 0, 0, 0,
        0, 1, 0, 0, 0, 0,
        0, 0, 0, 0, 0,
        0,
        1, 1,
        0, 0,
        1, 0, 1,
        0, 1,
        0, 0, 0
    };

    initial begin
        int s0;
        int e0;
        longint pk_exp;

        tbl[0] = '{2'd0, 4'd1,  TMAX,     8'd0, 6,  4, 1'b0};
        tbl[1] = '{2'd1, 4'd1,  39999,    8'd2, 7,  6, 1'b0};
        tbl[2] = '{2'd3, 4'd3,  TMAX,     8'd0, 8,  5, 1'b0};
        tbl[3] = '{2'd2, 4'd1,  TMAX,     8'd0, 2,  1, 1'b0};
        tbl[4] = '{2'd2, 4'd0,  0,        8'd0, 3,  2, 1'b0};
        tbl[5] = '{2'd1, 4'd15, 10000,    8'd0, 10, 2, 1'b0};
        tbl[6] = '{2'd0, 4'd1,  0,        8'd1, 5,  3, 1'b1};
        tbl[7] = '{2'd2, 4'd2,  -1,       8'd0, 4,  2, 1'b0};
        tbl[8] = '{2'd1, 4'd2,  TMAX,     8'd0, 5,  3, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; data_in = '0; cfg_load = 1'b0;
        mode = '0; k_sel = '0; threshold = '0; refract_len = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_op_out", op_out, 0);
        check("rst_event", spike, 0);
        check("rst_peak", peak_out, 0);
        check("rst_busy", busy, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Two-cycle latency with the reset configuration (TKEO): 2^2 - 3*1 = 1
        idle(2);
        send(1); idle(3);
        send(2); idle(3);
        @(posedge clk); #1;
        in_valid = 1'b1; data_in = 16'sd3;
        @(negedge clk);
        check("lat_t0_valid", out_valid, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_t1_valid", out_valid, 0);
        @(negedge clk);
        check("lat_t2_valid", out_valid, 1);
        check("lat_t2_op", op_out, 1);
        @(negedge clk);
        check("lat_t3_valid", out_valid, 0);
        idle(3);

        // Table-driven vectors
        s0 = 0;
        e0 = 0;
        for (int v = 0; v < NV; v++) begin
            configure(tbl[v].mode, tbl[v].k, tbl[v].thr, tbl[v].rlen);
            clear_q();
            for (int i = 0; i < tbl[v].ns; i++) send(samp[s0 + i]);
            idle(5);
            check($sformatf("v%0d_count", v), q_op.size(), tbl[v].ne);
            for (int i = 0; i < tbl[v].ne; i++) begin
                if (i < q_op.size()) begin
                    check($sformatf("v%0d_op%0d", v, i), q_op[i], exp_op[e0 + i] >>> SCALE_SH);
                    check($sformatf("v%0d_ev%0d", v, i), q_ev[i], exp_ev[e0 + i]);
                end
            end
            check($sformatf("v%0d_busy", v), busy, tbl[v].busy_end);
            s0 += tbl[v].ns;
            e0 += tbl[v].ne;
        end

        // cfg_load while refractory with a sample in flight and one in the same cycle
        configure(2'd1, 4'd1, 39999, 8'd5);
        clear_q();
        send(0); send(200); send(0); send(0);
        @(posedge clk); #1;
        cfg_load = 1'b1; in_valid = 1'b1; data_in = 16'sd999;
        mode = 2'd3; k_sel = 4'd1; threshold = OUT_W'(TMAX); refract_len = 8'd0;
`ifdef NLO_PEAK_HOLD_EN
        pk_exp = 40000;
`else
        pk_exp = 0;
`endif
        @(negedge clk);
        check("cfg_peak_before", peak_out, pk_exp);
        check("cfg_busy_refract", busy, 1);
        @(posedge clk); #1;
        cfg_load = 1'b0; in_valid = 1'b0;
        idle(4);
        check("cfg_no_extra_results", q_op.size(), 2);
        if (q_ev.size() > 0) check("cfg_first_event", q_ev[0], 1);
        check("cfg_busy_after", busy, 1);
        check("cfg_peak_cleared", peak_out, 0);
        send(7); send(10); idle(4);
        check("cfg_new_count", q_op.size(), 3);
        if (q_op.size() > 2) check("cfg_new_op", q_op[2], 3 >>> SCALE_SH);
        check("cfg_new_busy", busy, 0);

        // Asynchronous reset mid-stream with results in flight
        configure(2'd1, 4'd2, TMAX, 8'd0);
        clear_q();
        send(0); send(3); send(10); send(-2);
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_op_out", op_out, 0);
        check("mrst_event", spike, 0);
        check("mrst_busy", busy, 1);
        clear_q();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(4);
        check("mrst_no_inflight", q_op.size(), 0);
        // Warmup restarts in reset configuration (TKEO): 5^2 - 6*4 = 1
        send(4); send(5); idle(4);
        check("mrst_warmup_count", q_op.size(), 0);
        send(6); idle(4);
        check("mrst_first_count", q_op.size(), 1);
        if (q_op.size() > 0) check("mrst_first_op", q_op[0], 1 >>> SCALE_SH);

        // Gapped samples must match the back-to-back ED k2 vector (V8)
        configure(2'd1, 4'd2, TMAX, 8'd0);
        clear_q();
        for (int i = 0; i < 5; i++) begin
            send(samp[45 + i]);
            idle(3);
        end
        idle(2);
        check("gap_count", q_op.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < q_op.size()) check($sformatf("gap_op%0d", i), q_op[i], exp_op[25 + i] >>> SCALE_SH);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
